// File: rtl/audio_pkg.sv
// Package: audio_pkg
// Shared constants and helpers for the audio mixer slice.
//   DEF_NCH / DEF_W / DEF_VW : default channel count, sample width, volume width
//   LFSR_SEED / LFSR_TAPS    : dither LFSR reset value and feedback taps (16,14,13,11)
//   clog2()                  : ceil(log2(n)), never less than 1 (index width)
//   lfsr_step()              : one shift of the 16-bit Fibonacci dither LFSR
package audio_pkg;

    localparam int DEF_NCH = 2;
    localparam int DEF_W   = 6;
    localparam int DEF_VW  = 4;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Bit positions 15,13,12,10 correspond to taps 16,14,13,11.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/sd_mod.sv
// Module: sd_mod
// First-order sigma-delta modulator producing a 1-bit stream whose ones
// density is sum / 2^S.
// Ports:
//   clock  in  1   system clock, one modulator step per cycle
//   reset  in  1   synchronous, active-high; clears the integrator
//   sum    in  S   unsigned level to modulate
//   cin    in  1   carry-in added each step (dither source or 0)
//   q      out 1   registered output bit (integrator carry)
module sd_mod #(
    parameter int S = 11
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [S-1:0] sum,
    input  logic         cin,
    output logic         q
);

    // Top bit is the carry of the previous step; it is dropped before the
    // next addition so the integrator wraps modulo 2^S.
    logic [S:0] sd_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            sd_reg <= '0;
        end else begin
            sd_reg <= {1'b0, sd_reg[S-1:0]} + {1'b0, sum} + {{S{1'b0}}, cin};
        end
    end

    assign q = sd_reg[S];

endmodule

// File: rtl/audio_mixer.sv
// Module: audio_mixer
// N-channel audio mixer: per-channel volume and left/right routing, one
// channel multiplied and accumulated per clock, frame sums latched every NCH
// clocks and fed to two first-order sigma-delta modulators.
// Build option: define AUDIO_DITHER_EN to add a 16-bit LFSR whose bit 0 is
// the carry-in of both modulators; otherwise the carry-in is 0 and the
// output is fully deterministic.
// Ports:
//   clock   in   1        system clock
//   reset   in   1        synchronous, active-high
//   ch      in   NCH*W    packed unsigned samples, channel i = ch[i*W +: W]
//   vol     in   NCH*VW   packed volumes, channel i = vol[i*VW +: VW]
//   pl      in   NCH      route channel i to left
//   pr      in   NCH      route channel i to right
//   strobe  out  1        one-cycle pulse after a new frame sum is latched
//   audio   out  2        {left, right} sigma-delta bit streams
module audio_mixer
    import audio_pkg::*;
#(
    parameter int NCH = DEF_NCH,
    parameter int W   = DEF_W,
    parameter int VW  = DEF_VW
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NCH*W-1:0]  ch,
    input  logic [NCH*VW-1:0] vol,
    input  logic [NCH-1:0]    pl,
    input  logic [NCH-1:0]    pr,
    output logic              strobe,
    output logic [1:0]        audio
);

    localparam int IW = clog2(NCH);
    localparam int PW = W + VW;
    // Wide enough for NCH full-scale products, so the sum can never wrap.
    localparam int S  = PW + IW;

    logic [W-1:0]  ch_arr  [NCH];
    logic [VW-1:0] vol_arr [NCH];

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_unpack
            assign ch_arr[gi]  = ch[gi*W +: W];
            assign vol_arr[gi] = vol[gi*VW +: VW];
        end
    endgenerate

    logic [IW-1:0] idx_reg;
    logic [S-1:0]  acc_l_reg, acc_r_reg;
    logic [S-1:0]  sum_l_reg, sum_r_reg;
    logic          strobe_reg;

    logic [PW-1:0] prod;
    logic [S-1:0]  add_l, add_r;
    logic          last_slot;
    logic          cin;

    // Only the channel currently addressed by the sequencer is looked at, so
    // later changes to already-processed channels wait for the next frame.
    assign prod      = PW'(ch_arr[idx_reg]) * PW'(vol_arr[idx_reg]);
    assign add_l     = pl[idx_reg] ? S'(prod) : '0;
    assign add_r     = pr[idx_reg] ? S'(prod) : '0;
    assign last_slot = (idx_reg == IW'(NCH - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            idx_reg    <= '0;
            acc_l_reg  <= '0;
            acc_r_reg  <= '0;
            sum_l_reg  <= '0;
            sum_r_reg  <= '0;
            strobe_reg <= 1'b0;
        end else if (last_slot) begin
            // Fold the final slot straight into the latched sum.
            idx_reg    <= '0;
            sum_l_reg  <= acc_l_reg + add_l;
            sum_r_reg  <= acc_r_reg + add_r;
            acc_l_reg  <= '0;
            acc_r_reg  <= '0;
            strobe_reg <= 1'b1;
        end else begin
            idx_reg    <= idx_reg + IW'(1);
            acc_l_reg  <= acc_l_reg + add_l;
            acc_r_reg  <= acc_r_reg + add_r;
            strobe_reg <= 1'b0;
        end
    end

    assign strobe = strobe_reg;

`ifdef AUDIO_DITHER_EN
    logic [15:0] lfsr_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_reg <= LFSR_SEED;
        end else begin
            lfsr_reg <= lfsr_step(lfsr_reg);
        end
    end

    assign cin = lfsr_reg[0];
`else
    assign cin = 1'b0;
`endif

    sd_mod #(.S(S)) u_sd_left (
        .clock (clock),
        .reset (reset),
        .sum   (sum_l_reg),
        .cin   (cin),
        .q     (audio[1])
    );

    sd_mod #(.S(S)) u_sd_right (
        .clock (clock),
        .reset (reset),
        .sum   (sum_r_reg),
        .cin   (cin),
        .q     (audio[0])
    );

endmodule

// File: tb/tb_audio_mixer.sv
// Testbench: tb_audio_mixer
// Scoreboard bench for audio_mixer (NCH=2, W=6, VW=4, S=11). The stimulus
// side records what each channel slot saw and, at frame end, pushes the
// expected left/right sums; a monitor pops them on every strobe.
`timescale 1ns/1ps
module tb_audio_mixer;

    localparam int NCH  = 2;
    localparam int W    = 6;
    localparam int VW   = 4;
    localparam int CHW  = NCH * W;
    localparam int VOLW = NCH * VW;
`ifdef AUDIO_DITHER_EN
    localparam int DTOL   = 1;
    localparam bit DITHER = 1'b1;
`else
    localparam int DTOL   = 0;
    localparam bit DITHER = 1'b0;
`endif

    logic            clock = 1'b0;
    logic            reset;
    logic [CHW-1:0]  ch;
    logic [VOLW-1:0] vol;
    logic [NCH-1:0]  pl;
    logic [NCH-1:0]  pr;
    logic            strobe;
    logic [1:0]      audio;

    audio_mixer #(.NCH(NCH), .W(W), .VW(VW)) dut (
        .clock  (clock),
        .reset  (reset),
        .ch     (ch),
        .vol    (vol),
        .pl     (pl),
        .pr     (pr),
        .strobe (strobe),
        .audio  (audio)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    int exp_l_q[$];
    int exp_r_q[$];
    bit exp_strobe = 1'b0;

    // Reference model state: which channel slot the next clock serves, and
    // the values each channel presented in its own slot this frame.
    int m_slot = 0;
    int f_ch  [NCH];
    int f_vol [NCH];
    bit f_pl  [NCH];
    bit f_pr  [NCH];

    int ones_l;
    int ones_r;

    task automatic check(input string name, input int act, input int exp, input int tol);
        checks++;
        if (act < exp - tol || act > exp + tol) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d tol=%0d t=%0t", name, act, exp, tol, $time);
        end
    endtask

    // Called right after a falling edge with inputs already applied; returns
    // at the next falling edge after the DUT has clocked them in.
    task automatic tick();
        int sl;
        int sr;
        exp_strobe = 1'b0;
        if (reset) begin
            m_slot = 0;
        end else begin
            f_ch[m_slot]  = int'(ch[m_slot*W +: W]);
            f_vol[m_slot] = int'(vol[m_slot*VW +: VW]);
            f_pl[m_slot]  = pl[m_slot];
            f_pr[m_slot]  = pr[m_slot];
            if (m_slot == NCH - 1) begin
                sl = 0;
                sr = 0;
                for (int c = 0; c < NCH; c++) begin
                    if (f_pl[c]) sl += f_ch[c] * f_vol[c];
                    if (f_pr[c]) sr += f_ch[c] * f_vol[c];
                end
                exp_l_q.push_back(sl);
                exp_r_q.push_back(sr);
                exp_strobe = 1'b1;
                m_slot = 0;
            end else begin
                m_slot++;
            end
        end
        @(negedge clock);
        ones_l += int'(audio[1]);
        ones_r += int'(audio[0]);
    endtask

    task automatic set_in(input int c0, input int c1, input int v0, input int v1,
                          input logic [1:0] l, input logic [1:0] r);
        ch  = {W'(c1), W'(c0)};
        vol = {VW'(v1), VW'(v0)};
        pl  = l;
        pr  = r;
    endtask

    task automatic count_window(input string nl, input string nr, input int el, input int er,
                                input int tl, input int tr, input int len);
        ones_l = 0;
        ones_r = 0;
        repeat (len) tick();
        check(nl, ones_l, el, tl);
        check(nr, ones_r, er, tr);
        $display("window %s/%s len=%0d ones_l=%0d ones_r=%0d", nl, nr, len, ones_l, ones_r);
    endtask

    // Monitor: strobe must match the model every cycle; each strobe pops one frame.
    initial begin : monitor
        int el;
        int er;
        forever begin
            @(posedge clock);
            #1;
            checks++;
            if (strobe !== exp_strobe) begin
                failures++;
                $display("FAIL strobe actual=%b expected=%b t=%0t", strobe, exp_strobe, $time);
            end
            if (strobe === 1'b1) begin
                if (exp_l_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL frame_unexpected actual=strobe expected=no_frame t=%0t", $time);
                end else begin
                    el = exp_l_q.pop_front();
                    er = exp_r_q.pop_front();
                    check("frame_sum_l", int'(dut.sum_l_reg), el, 0);
                    check("frame_sum_r", int'(dut.sum_r_reg), er, 0);
                end
            end
        end
    end

    initial begin : stimulus
        int el;
        int er;
        reset = 1'b1;
        set_in(0, 0, 0, 0, 2'b00, 2'b00);
        ones_l = 0;
        ones_r = 0;
        @(negedge clock);

        // 1: reset behaviour and idle strobe cadence
        repeat (3) begin
            tick();
            check("reset_audio", int'(audio), 0, 0);
            check("reset_strobe", int'(strobe), 0, 0);
        end
        reset = 1'b0;
        repeat (10) begin
            tick();
            check("idle_audio", int'(audio), 0, 0);
        end

        // 2: channel 0 full scale to left only
        set_in(63, 0, 15, 0, 2'b01, 2'b00);
        repeat (8) tick();
        check("t2_sum_l", int'(dut.sum_l_reg), 945, 0);
        check("t2_sum_r", int'(dut.sum_r_reg), 0, 0);
        count_window("t2_ones_l", "t2_ones_r", 945, 0, 1 + DTOL, DTOL, 2048);

        // 3: both channels full scale to both sides
        set_in(63, 63, 15, 15, 2'b11, 2'b11);
        repeat (8) tick();
        check("t3_sum_l", int'(dut.sum_l_reg), 1890, 0);
        check("t3_sum_r", int'(dut.sum_r_reg), 1890, 0);
        count_window("t3_ones_l", "t3_ones_r", 1890, 1890, 1 + DTOL, 1 + DTOL, 2048);

        // 4: mid-frame volume changes
        while (m_slot != 0) tick();
        set_in(63, 63, 15, 0, 2'b11, 2'b11);
        tick();
        tick();
        check("t4_vol1_early", int'(dut.sum_l_reg), 945, 0);
        set_in(63, 63, 15, 15, 2'b11, 2'b11);
        tick();
        set_in(63, 63, 0, 15, 2'b11, 2'b11);
        tick();
        check("t4_vol0_late", int'(dut.sum_l_reg), 1890, 0);
        tick();
        tick();
        check("t4_vol0_next", int'(dut.sum_l_reg), 945, 0);

        // 5: one-cycle reset in the middle of a frame
        set_in(63, 63, 15, 15, 2'b11, 2'b11);
        repeat (40) tick();
        while (m_slot != 1) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_audio", int'(audio), 0, 0);
        check("t5_strobe", int'(strobe), 0, 0);
        check("t5_idx", int'(dut.idx_reg), 0, 0);
        check("t5_sum_l", int'(dut.sum_l_reg), 0, 0);
        tick();
        check("t5_strobe_rel1", int'(strobe), 0, 0);
        tick();
        check("t5_strobe_rel2", int'(strobe), 1, 0);

        // Random static patterns: latched sums and ones density
        for (int k = 0; k < 3; k++) begin
            ch  = CHW'($urandom());
            vol = VOLW'($urandom());
            pl  = NCH'($urandom());
            pr  = NCH'($urandom());
            el = 0;
            er = 0;
            for (int c = 0; c < NCH; c++) begin
                if (pl[c]) el += int'(ch[c*W +: W]) * int'(vol[c*VW +: VW]);
                if (pr[c]) er += int'(ch[c*W +: W]) * int'(vol[c*VW +: VW]);
            end
            repeat (8) tick();
            check("rnd_sum_l", int'(dut.sum_l_reg), el, 0);
            check("rnd_sum_r", int'(dut.sum_r_reg), er, 0);
            count_window("rnd_ones_l", "rnd_ones_r", el, er, 1 + DTOL, 1 + DTOL, 2048);
        end

        // Random inputs changing every cycle: scoreboard checks each frame
        repeat (400) begin
            ch  = CHW'($urandom());
            vol = VOLW'($urandom());
            pl  = NCH'($urandom());
            pr  = NCH'($urandom());
            tick();
        end

        // Silence over a long window: dither only contributes ones
        set_in(0, 0, 0, 0, 2'b00, 2'b00);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        count_window("quiet_ones_l", "quiet_ones_r",
                     DITHER ? 16 : 0, DITHER ? 16 : 0,
                     DITHER ? 2 : 0, DITHER ? 2 : 0, 65536);

        tick();
        check("leftover_frames", exp_l_q.size(), 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
